// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Runs the inhibit / request-to-send sequence, then shifts one command byte
// out LSB first with odd parity and a stop bit, clocked by the device. It
// finishes by sampling the device's acknowledge bit. Both PS/2 lines are
// open-drain, so the outputs are pull-low enables rather than pin levels.
//
// Handshake: `send` is looked at only while idle (busy = 0), and never in the
// cycle `done` is high. An accepted `send` captures `tx_data` and raises
// `busy` from the next cycle. `done` pulses for exactly one cycle, with
// `busy` already low. `ack_ok` and `error` are valid in that cycle and hold
// until the next accepted `send`. A `send` while busy is dropped, not queued.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       send,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [2:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        clk_fall;
    logic        data_s;
    logic        lines_idle;
    logic        accept;
    logic        timeout;
    logic [7:0]  tx_q;
    // Bit 0 is the bit currently on the wire; the start bit sits below the
    // data so that the first device clock edge simply shifts to d0.
    logic [10:0] shreg;
    logic [3:0]  bit_cnt;
    // Shared counter: inhibit length while in INHIBIT, gap between device
    // clock falling edges while the device is clocking.
    logic [19:0] cnt;

    assign clk_fall   = clk_sync[2] & ~clk_sync[1];
    assign data_s     = data_sync[1];
    assign lines_idle = clk_sync[2] & data_s;
    assign accept     = (state == IDLE) && send && !done;
    assign timeout    = ((state == SHIFT) || (state == ACK) || (state == WAIT_IDLE))
                        && (cnt == TIMEOUT_LAST);

    // Bring the asynchronous PS/2 pin levels into the clk domain.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a timeout from any device-clocked state aborts to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (accept) next_state = INHIBIT;
            INHIBIT:   if (cnt == INHIBIT_LAST) next_state = REQ;
            REQ:       next_state = SHIFT;
            SHIFT: begin
                if (timeout)                          next_state = IDLE;
                else if (clk_fall && bit_cnt == 4'd9) next_state = ACK;
            end
            ACK: begin
                if (timeout)       next_state = IDLE;
                else if (clk_fall) next_state = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (timeout || lines_idle) next_state = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end

    // Line enables and busy decoded from the registered state.
    always_comb begin
        ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
        ps2_data_oe = (state == REQ) || ((state == SHIFT) && !shreg[0]);
        busy        = (state != IDLE);
    end

    // Frame shifting, bit and cycle counting, and the end-of-transaction flags.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tx_q    <= 8'h00;
            shreg   <= 11'h7ff;
            bit_cnt <= 4'd0;
            cnt     <= 20'd0;
            done    <= 1'b0;
            ack_ok  <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                tx_q   <= tx_data;
                ack_ok <= 1'b0;
                error  <= 1'b0;
            end

            // Load {stop, odd parity, data, start} as REQ begins driving the start bit.
            if ((state == INHIBIT) && (next_state == REQ)) begin
                shreg <= {1'b1, ~^tx_q, tx_q, 1'b0};
            end else if ((state == SHIFT) && clk_fall && !timeout) begin
                shreg <= {1'b1, shreg[10:1]};
            end

            if (state == REQ) begin
                bit_cnt <= 4'd0;
            end else if ((state == SHIFT) && clk_fall) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if ((state == IDLE) || (state == REQ)) begin
                cnt <= 20'd0;
            end else if (state == INHIBIT) begin
                cnt <= cnt + 20'd1;
            end else if (clk_fall) begin
                cnt <= 20'd0;
            end else begin
                cnt <= cnt + 20'd1;
            end

            if ((state == ACK) && clk_fall && !timeout) begin
                ack_ok <= ~data_s;
            end

            if (timeout) begin
                done   <= 1'b1;
                error  <= 1'b1;
                ack_ok <= 1'b0;
            end else if ((state == WAIT_IDLE) && lines_idle) begin
                done <= 1'b1;
            end
        end
    end

endmodule
